// File: rtl/cpu_bram_dp.sv
// cpu_bram_dp: dual-port byte-maskable block RAM for the CPU subsystem.
// Port A serves loads/stores and port B serves instruction fetch or DMA.
// Each port has a fully pipelined request/ready handshake with no backpressure.
// READ_LATENCY can be 1 or 2. A latency of 2 adds one output register stage.
// Optional feature: define CPU_BRAM_DP_PARITY_EN to store one even-parity bit
// per byte. The define also adds the i_parity_inject and o_parity_error ports.

// Per-port completion pipeline. It carries the handshake from the accept
// edge to o_ready and holds rdata/valid between completions.
module cpu_bram_dp_port #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_acc,      // request accepted this edge
    input  logic             i_rng,      // accepted request is in range
    input  logic             i_ld,       // accepted request is an in-range read
    input  logic             i_bad,      // stage-1 read failed its integrity check
    input  logic [WIDTH-1:0] i_rd_data,  // memory word captured on the accept edge
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_ready,
    output logic             o_valid
);
    logic [STAGES:1] vld_pipe;
    logic            rng_q;
    logic            ld_q;
    logic            out_ok;
    logic            out_ld;
    logic [WIDTH-1:0] out_dat;
    logic [WIDTH-1:0] hold_dat;
    logic            hold_ok;

    // Stage 1 captures the control bits on the accept edge, alongside the memory read.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            vld_pipe <= '0;
            rng_q    <= 1'b0;
            ld_q     <= 1'b0;
        end else begin
            vld_pipe[1] <= i_acc;
            for (int k = 2; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
            rng_q <= i_rng;
            ld_q  <= i_ld;
        end
    end

    if (STAGES == 2) begin : g_out_reg
        logic             ok_q;
        logic             ld2_q;
        logic [WIDTH-1:0] dat_q;

        // At latency 2, ready, valid and data move together into the output register.
        always_ff @(posedge i_clock or negedge i_reset_n) begin
            if (!i_reset_n) begin
                ok_q  <= 1'b0;
                ld2_q <= 1'b0;
                dat_q <= '0;
            end else begin
                ok_q  <= rng_q & ~i_bad;
                ld2_q <= ld_q;
                dat_q <= i_rd_data;
            end
        end
        assign out_ok  = ok_q;
        assign out_ld  = ld2_q;
        assign out_dat = dat_q;
    end else begin : g_out_comb
        assign out_ok  = rng_q & ~i_bad;
        assign out_ld  = ld_q;
        assign out_dat = i_rd_data;
    end

    assign o_ready = vld_pipe[STAGES];
    // Only in-range reads refresh rdata. Every completion refreshes valid.
    assign o_rdata = out_ld ? out_dat : hold_dat;
    assign o_valid = o_ready ? out_ok : hold_ok;

    // Remember the last completion so the outputs hold between ready pulses.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hold_dat <= '0;
            hold_ok  <= 1'b1;
        end else begin
            hold_dat <= o_rdata;
            hold_ok  <= o_valid;
        end
    end
endmodule

module cpu_bram_dp #(
    parameter int          WIDTH        = 32,
    parameter int unsigned SIZE         = 32'h00000400,
    parameter int          ADDR_LSH     = 2,
    parameter int          READ_LATENCY = 1
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_a_request,
    input  logic               i_a_rw,
    input  logic [31:0]        i_a_address,
    input  logic [WIDTH-1:0]   i_a_wdata,
    input  logic [WIDTH/8-1:0] i_a_wmask,
    output logic [WIDTH-1:0]   o_a_rdata,
    output logic               o_a_ready,
    output logic               o_a_valid,
    input  logic               i_b_request,
    input  logic               i_b_rw,
    input  logic [31:0]        i_b_address,
    input  logic [WIDTH-1:0]   i_b_wdata,
    input  logic [WIDTH/8-1:0] i_b_wmask,
    output logic [WIDTH-1:0]   o_b_rdata,
    output logic               o_b_ready,
    output logic               o_b_valid
`ifdef CPU_BRAM_DP_PARITY_EN
    ,
    input  logic               i_parity_inject,
    output logic               o_parity_error
`endif
);
    localparam int NB = WIDTH / 8;
    localparam int NP = 2;
    localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef struct packed {
        logic             rw;
        logic [31:0]      addr;
        logic [WIDTH-1:0] wdata;
        logic [NB-1:0]    wmask;
    } req_t;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("cpu_bram_dp: READ_LATENCY must be 1 or 2");
    end

    req_t [NP-1:0]            rq;
    logic [NP-1:0]            req;
    logic [NP-1:0][31:0]      idx;
    logic [NP-1:0][AW-1:0]    widx;
    logic [NP-1:0]            in_rng;
    logic [NP-1:0]            acc;
    logic [NP-1:0]            wr_en;
    logic [NP-1:0]            rd_ld;
    logic [NP-1:0]            bad;
    logic [NP-1:0][WIDTH-1:0] rd_q;
    logic [NP-1:0][WIDTH-1:0] rdata;
    logic [NP-1:0]            ready;
    logic [NP-1:0]            valid;

    logic [WIDTH-1:0] mem [SIZE];

    assign req   = {i_b_request, i_a_request};
    assign rq[0] = '{rw: i_a_rw, addr: i_a_address, wdata: i_a_wdata, wmask: i_a_wmask};
    assign rq[1] = '{rw: i_b_rw, addr: i_b_address, wdata: i_b_wdata, wmask: i_b_wmask};

    for (genvar p = 0; p < NP; p++) begin : g_lane
        // The range check uses the full 32-bit index so that high addresses cannot alias.
        assign idx[p]    = rq[p].addr >> ADDR_LSH;
        assign widx[p]   = idx[p][AW-1:0];
        assign in_rng[p] = idx[p] < SIZE;
        assign acc[p]    = req[p] & i_reset_n;
        assign wr_en[p]  = acc[p] & in_rng[p] & rq[p].rw;
        assign rd_ld[p]  = acc[p] & in_rng[p] & ~rq[p].rw;

        cpu_bram_dp_port #(
            .WIDTH  (WIDTH),
            .STAGES (READ_LATENCY)
        ) u_port (
            .i_clock   (i_clock),
            .i_reset_n (i_reset_n),
            .i_acc     (acc[p]),
            .i_rng     (in_rng[p]),
            .i_ld      (rd_ld[p]),
            .i_bad     (bad[p]),
            .i_rd_data (rd_q[p]),
            .o_rdata   (rdata[p]),
            .o_ready   (ready[p]),
            .o_valid   (valid[p])
        );
    end

    // Byte-masked writes. Port B is applied first, so port A wins any byte both ports enable.
    always_ff @(posedge i_clock) begin
        for (int p = NP - 1; p >= 0; p--) begin
            if (wr_en[p]) begin
                for (int b = 0; b < NB; b++) begin
                    if (rq[p].wmask[b]) mem[widx[p]][8*b +: 8] <= rq[p].wdata[8*b +: 8];
                end
            end
        end
    end

    // Registered read on both ports. It returns the word as it was before this edge's writes.
    always_ff @(posedge i_clock) begin
        for (int p = 0; p < NP; p++) rd_q[p] <= mem[widx[p]];
    end

`ifdef CPU_BRAM_DP_PARITY_EN
    logic [NB-1:0]          par_mem [SIZE];
    logic [NP-1:0][NB-1:0]  par_q;
    logic [NP-1:0]          chk_q;

    function automatic logic [NB-1:0] byte_par(input logic [WIDTH-1:0] d);
        logic [NB-1:0] r;
        for (int b = 0; b < NB; b++) r[b] = ^d[8*b +: 8];
        return r;
    endfunction

    // Each parity bit is written with its data byte. The inject input flips it, so tests can force an error.
    always_ff @(posedge i_clock) begin
        for (int p = NP - 1; p >= 0; p--) begin
            if (wr_en[p]) begin
                for (int b = 0; b < NB; b++) begin
                    if (rq[p].wmask[b])
                        par_mem[widx[p]][b] <= (^rq[p].wdata[8*b +: 8]) ^ i_parity_inject;
                end
            end
        end
        for (int p = 0; p < NP; p++) par_q[p] <= par_mem[widx[p]];
    end

    // Track which stage-1 words are real reads that need a parity check.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) chk_q <= '0;
        else            chk_q <= rd_ld;
    end

    for (genvar p = 0; p < NP; p++) begin : g_par
        assign bad[p] = chk_q[p] & (|(byte_par(rd_q[p]) ^ par_q[p]));
    end

    // The error flag is sticky and only reset clears it.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)  o_parity_error <= 1'b0;
        else if (|bad)   o_parity_error <= 1'b1;
    end
`else
    assign bad = '0;
`endif

    assign o_a_rdata = rdata[0];
    assign o_a_ready = ready[0];
    assign o_a_valid = valid[0];
    assign o_b_rdata = rdata[1];
    assign o_b_ready = ready[1];
    assign o_b_valid = valid[1];
endmodule

// File: doc/cpu_bram_dp.md
Name: cpu_bram_dp

Overview:
- Dual-port, byte-maskable block RAM for the CPU subsystem.
- Port A serves data load/store and port B serves instruction fetch or DMA.
- Generalises the single-port CPU BRAM: configurable width and depth, per-byte write mask, selectable 1- or 2-cycle read latency, and fully pipelined request/ready handshake on both ports.
- Out-of-range accesses are flagged per transaction and never corrupt memory.

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8.
- SIZE, 32'h00000400, depth in words.
- ADDR_LSH, 2, right shift applied to the byte address to form the word index.
- READ_LATENCY, 1, cycles from accepted request to o_x_ready; legal values 1 or 2 (2 adds an output register).

Ports:
- i_clock  in  1  clock, all logic on rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_a_request  in  1  port A request; sampled every cycle.
- i_a_rw  in  1  port A direction; 0 = read, 1 = write.
- i_a_address  in  32  port A byte address.
- i_a_wdata  in  WIDTH  port A write data.
- i_a_wmask  in  WIDTH/8  port A byte enables; bit n covers bits [8n+7:8n].
- o_a_rdata  out  WIDTH  port A read data.
- o_a_ready  out  1  port A completion pulse.
- o_a_valid  out  1  port A address in range; qualifies the completion.
- i_b_request, i_b_rw, i_b_address, i_b_wdata, i_b_wmask, o_b_rdata, o_b_ready, o_b_valid: identical to port A, for port B.

Behaviour:
- Reset (i_reset_n low, asynchronous):
  - o_x_ready = 0, o_x_valid = 1, o_x_rdata = 0, pipeline stages cleared.
  - Memory contents are not cleared.
  - Requests are ignored and no write occurs while reset is low.
- Index: idx = i_x_address >> ADDR_LSH. In range when idx < SIZE, compared using the full 32-bit value.
- Handshake:
  - No backpressure; a request is accepted every cycle i_x_request = 1.
  - Each accepted request produces exactly one o_x_ready pulse, READ_LATENCY cycles later, for reads and writes alike.
  - o_x_valid and o_x_rdata are updated in the same cycle as that o_x_ready pulse.
  - Back-to-back requests give back-to-back ready pulses, in order.
- Read:
  - o_x_rdata = data[idx] as of the accept edge (read-first).
  - On a write completion, o_x_rdata holds its previous value.
- Write:
  - Only bytes with i_x_wmask[n] = 1 are updated, on the accept edge.
  - A mask of all zeros completes normally and leaves memory unchanged.
- Out of range:
  - No memory access takes place.
  - o_x_valid = 0 with that transaction's ready pulse; o_x_rdata holds its previous value.
  - o_x_valid returns to 1 on the next in-range completion; it otherwise holds.
- Collisions (same idx on both ports, same cycle):
  - Write A / write B: per byte, A wins where both mask bits are set; each port's exclusively masked bytes are written.
  - Write on one port / read on the other: the read returns old data.
  - Read / read: both return the same data.
- READ_LATENCY = 2: stage-1 result is registered once more; ready, valid and rdata all shift together.
- Reset asserted mid-transaction: in-flight ready pulses are dropped and never appear after release.
  - A write accepted on an edge before reset assertion is retained in memory.
- First request is accepted on the first rising edge after i_reset_n deasserts.

Optional Feature:
- Macro: CPU_BRAM_DP_PARITY_EN.
- When defined:
  - One even-parity bit is stored per byte and written alongside each masked byte.
  - Reads recompute parity; a mismatch in any byte asserts a sticky output o_parity_error (1 bit, reset 0).
  - The erroring port's completion gets o_x_valid = 0.
  - o_parity_error clears only on reset.
  - A test-only input i_parity_inject (1 bit) inverts the stored parity for writes accepted while it is high.
- When undefined:
  - Neither port exists, no parity storage is inferred, and behaviour is as above.

Test Plan:
- Reset, then A writes 32'hDEADBEEF at 0x10 with mask 4'hF, then A reads 0x10 -> o_a_ready one cycle after each request; read returns DEADBEEF with valid = 1.
- A writes 32'h11223344 at 0x20 with mask 4'b0101 over existing 32'hFFFFFFFF -> B read of 0x20 returns 32'hFF22FF44.
- A reads 0x1000 (idx 1024 = SIZE) -> ready pulse with valid = 0 and rdata unchanged; next in-range read gives valid = 1.
- Same cycle: A writes 32'hAAAAAAAA mask F and B writes 32'h55555555 mask F, both at 0x40 -> subsequent read = AAAAAAAA.
  - In a separate same-cycle case, A writes and B reads the same word -> B gets old data.
- READ_LATENCY = 2: four back-to-back reads of 0x0, 0x4, 0x8, 0xC -> four consecutive ready pulses starting 2 cycles later, data in order.
- Assert i_reset_n low between accept and ready of a read -> no ready pulse after release; memory retains earlier writes.
  - With CPU_BRAM_DP_PARITY_EN: inject-write then read -> o_parity_error = 1 and valid = 0.
